// File: rtl/rr_arbiter_pkg.sv
// Shared arbitration constants: tie-break direction names and the index-width helper
// used by the arbiter, its priority encoders and the interface.
package rr_arbiter_pkg;

    localparam string LSB_HIGH = "HIGH";
    localparam string LSB_LOW  = "LOW";

    function automatic int clog2_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface rr_arbiter_if
    import rr_arbiter_pkg::*;
#(
    parameter int PORTS = 4
);
    localparam int W_ENC = clog2_w(PORTS);

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [W_ENC-1:0] grant_encoded;

    modport master (
        output request,
        output acknowledge,
        input  grant,
        input  grant_valid,
        input  grant_encoded
    );

    modport slave (
        input  request,
        input  acknowledge,
        output grant,
        output grant_valid,
        output grant_encoded
    );

endinterface

// File: rtl/f_rr_arbiter.sv
// Property checker for rr_arbiter outputs: one-hot grant, encoding consistency,
// grants only to requesting ports, and the hold rules of the blocking mode.
module f_rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int ARB_BLOCK     = 1,
    parameter int ARB_BLOCK_ACK = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    input logic [PORTS-1:0]          request,
    input logic [PORTS-1:0]          acknowledge,
    input logic [PORTS-1:0]          grant,
    input logic                      grant_valid,
    input logic [clog2_w(PORTS)-1:0] grant_encoded
);
    localparam logic [PORTS-1:0] ONE = {{(PORTS-1){1'b0}}, 1'b1};

    logic hold_s;

    // Hold condition as seen by requesters in the current cycle.
    always_comb begin
        if (ARB_BLOCK_ACK != 0) begin
            hold_s = grant_valid && !(|(acknowledge & grant));
        end else if (ARB_BLOCK != 0) begin
            hold_s = grant_valid && (|(request & grant));
        end else begin
            hold_s = 1'b0;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_valid:  assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant));
    a_enc:    assert property (@(posedge clk) disable iff (!rst_n)
                               grant_valid |-> (grant == (ONE << grant_encoded)));
    a_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                               ($past(rst_n) && $past(hold_s)) |-> (grant == $past(grant)));
    a_req:    assert property (@(posedge clk) disable iff (!rst_n)
                               ($past(rst_n) && !$past(hold_s) && grant_valid)
                               |-> (|(grant & $past(request))));

endmodule

// File: rtl/rr_arbiter_priority_encoder.sv
// Combinational priority encoder; LSB_PRIORITY selects whether the lowest or the
// highest set index wins.
module priority_encoder
    import rr_arbiter_pkg::*;
#(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "HIGH"
) (
    input  logic [WIDTH-1:0]          input_unencoded_i,
    output logic                      output_valid_o,
    output logic [clog2_w(WIDTH)-1:0] output_encoded_o,
    output logic [WIDTH-1:0]          output_unencoded_o
);
    localparam int               W_ENC  = clog2_w(WIDTH);
    localparam bit               LSB_HI = (LSB_PRIORITY != LSB_LOW);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [W_ENC-1:0] enc_s;

    // Scan toward the winning end so the final hit overwrites earlier ones.
    always_comb begin
        enc_s = '0;
        if (LSB_HI) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                enc_s = input_unencoded_i[i] ? W_ENC'(i) : enc_s;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                enc_s = input_unencoded_i[i] ? W_ENC'(i) : enc_s;
            end
        end
    end

    assign output_valid_o     = |input_unencoded_i;
    assign output_encoded_o   = enc_s;
    assign output_unencoded_o = output_valid_o ? (ONE << enc_s) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection, with optional
// grant hold on request or until acknowledge.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int    PORTS         = 4,
    parameter int    ARB_RR        = 1,
    parameter int    ARB_BLOCK     = 1,
    parameter int    ARB_BLOCK_ACK = 1,
    parameter string LSB_PRIORITY  = "HIGH"
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arbiter_if.slave arb
);
    localparam int               W_ENC    = clog2_w(PORTS);
    localparam bit               LSB_HI   = (LSB_PRIORITY == LSB_HIGH);
    localparam logic [PORTS-1:0] ALL_ONES = {PORTS{1'b1}};

    logic [PORTS-1:0] mask_q, mask_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [W_ENC-1:0] enc_q, enc_d;
    logic             hold_s;
    logic             u_valid_s, m_valid_s;
    logic [W_ENC-1:0] u_enc_s, m_enc_s;
    logic [PORTS-1:0] u_onehot_s, m_onehot_s, masked_req_s;

    assign masked_req_s = arb.request & mask_q;

    priority_encoder #(.WIDTH(PORTS), .LSB_PRIORITY(LSB_PRIORITY)) u_enc_unmasked (
        .input_unencoded_i  (arb.request),
        .output_valid_o     (u_valid_s),
        .output_encoded_o   (u_enc_s),
        .output_unencoded_o (u_onehot_s)
    );

    priority_encoder #(.WIDTH(PORTS), .LSB_PRIORITY(LSB_PRIORITY)) u_enc_masked (
        .input_unencoded_i  (masked_req_s),
        .output_valid_o     (m_valid_s),
        .output_encoded_o   (m_enc_s),
        .output_unencoded_o (m_onehot_s)
    );

    // Decide whether the current owner keeps the grant this cycle.
    always_comb begin
        if (ARB_BLOCK_ACK != 0) begin
            hold_s = valid_q && !(|(arb.acknowledge & grant_q));
        end else if (ARB_BLOCK != 0) begin
            hold_s = valid_q && (|(arb.request & grant_q));
        end else begin
            hold_s = 1'b0;
        end
    end

    // Next grant and rotation mask; the mask only moves when a fresh grant is issued.
    always_comb begin
        grant_d = grant_q;
        valid_d = valid_q;
        enc_d   = enc_q;
        if (hold_s) begin
            grant_d = grant_q;
        end else if ((ARB_RR != 0) && m_valid_s) begin
            grant_d = m_onehot_s;
            valid_d = 1'b1;
            enc_d   = m_enc_s;
        end else if (u_valid_s) begin
            grant_d = u_onehot_s;
            valid_d = 1'b1;
            enc_d   = u_enc_s;
        end else begin
            grant_d = '0;
            valid_d = 1'b0;
        end

        if (!hold_s && valid_d && (ARB_RR != 0)) begin
            mask_d = LSB_HI ? (ALL_ONES << (int'(enc_d) + 32'sd1))
                            : (ALL_ONES >> (PORTS - int'(enc_d)));
        end else begin
            mask_d = mask_q;
        end
    end

    // Single output register stage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            enc_q   <= '0;
            mask_q  <= ALL_ONES;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            enc_q   <= enc_d;
            mask_q  <= mask_d;
        end
    end

    assign arb.grant         = grant_q;
    assign arb.grant_valid   = valid_q;
    assign arb.grant_encoded = enc_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: five configurations side by side, directed scenarios plus
// randomized traffic checked against a circular-scan reference model.
module tb_rr_arbiter;

    localparam int NDUT = 5;
    // dut0 RR/no-block/HIGH, dut1 RR/ack/HIGH, dut2 fixed/HIGH, dut3 fixed/LOW, dut4 RR/block/LOW
    localparam logic [NDUT-1:0] CFG_RR  = 5'b10011;
    localparam logic [NDUT-1:0] CFG_BLK = 5'b10010;
    localparam logic [NDUT-1:0] CFG_ACK = 5'b00010;
    localparam logic [NDUT-1:0] CFG_HI  = 5'b00111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NDUT-1:0][3:0] req_v;
    logic [NDUT-1:0][3:0] ack_v;
    logic [NDUT-1:0][3:0] gnt_o;
    logic [NDUT-1:0]      vld_o;
    logic [NDUT-1:0][1:0] enc_o;

    bit m_valid [NDUT];
    int m_g     [NDUT];
    int m_last  [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        localparam string LSBP = CFG_HI[d] ? "HIGH" : "LOW";
        rr_arbiter_if #(.PORTS(4)) bus ();
        assign bus.request     = req_v[d];
        assign bus.acknowledge = ack_v[d];
        assign gnt_o[d] = bus.grant;
        assign vld_o[d] = bus.grant_valid;
        assign enc_o[d] = bus.grant_encoded;

        rr_arbiter #(
            .PORTS(4), .ARB_RR(int'(CFG_RR[d])), .ARB_BLOCK(int'(CFG_BLK[d])),
            .ARB_BLOCK_ACK(int'(CFG_ACK[d])), .LSB_PRIORITY(LSBP)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .arb(bus)
        );

        f_rr_arbiter #(
            .PORTS(4), .ARB_BLOCK(int'(CFG_BLK[d])), .ARB_BLOCK_ACK(int'(CFG_ACK[d]))
        ) u_chk (
            .clk(clk), .rst_n(rst_n), .request(bus.request), .acknowledge(bus.acknowledge),
            .grant(bus.grant), .grant_valid(bus.grant_valid), .grant_encoded(bus.grant_encoded)
        );
    end

    // Winner = first requester met when walking circularly away from the last winner
    // (round robin) or from the preferred end (fixed priority); -1 when nobody asks.
    function automatic int pick(input logic [3:0] req, input int last, input bit rr, input bit hi);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            if (!rr) idx = hi ? (k - 1) : (4 - k);
            else     idx = hi ? ((last + k) % 4) : ((last - k + 8) % 4);
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt(input int d);
        return m_valid[d] ? (4'b0001 << m_g[d]) : 4'b0000;
    endfunction

    // Advance the reference model with the inputs about to be sampled, then step one clock.
    task automatic cycle();
        for (int d = 0; d < NDUT; d++) begin
            bit hold_m;
            int w;
            hold_m = CFG_ACK[d] ? (m_valid[d] && !ack_v[d][m_g[d]])
                   : CFG_BLK[d] ? (m_valid[d] && req_v[d][m_g[d]]) : 1'b0;
            if (!rst_n) begin
                m_valid[d] = 1'b0;
                m_g[d]     = 0;
                m_last[d]  = CFG_HI[d] ? 3 : 0;
            end else if (!hold_m) begin
                w = pick(req_v[d], m_last[d], CFG_RR[d], CFG_HI[d]);
                if (w >= 0) begin
                    m_valid[d] = 1'b1;
                    m_g[d]     = w;
                    m_last[d]  = w;
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            req_v[d] = 4'b1111;
            ack_v[d] = 4'b0000;
        end
        cycle();
        cycle();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (gnt_o[d] !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_grant dut%0d: got %b expected 0000", d, gnt_o[d]);
            end
            n_checks++;
            if (vld_o[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid dut%0d: got %b expected 0", d, vld_o[d]);
            end
            n_checks++;
            if (enc_o[d] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_encoded dut%0d: got %0d expected 0", d, enc_o[d]);
            end
        end
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if (gnt_o[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release_rr: got %b expected 0001", gnt_o[0]);
        end
        n_checks++;
        if (gnt_o[3] !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release_fixed_low: got %b expected 1000", gnt_o[3]);
        end
    endtask

    task automatic test_rr_rotation();
        logic [3:0] exp_g;
        do_reset();
        req_v[0] = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            exp_g = 4'b0001 << (i % 4);
            n_checks++;
            if (gnt_o[0] !== exp_g || enc_o[0] !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL rr_rotation step %0d: got %b/%0d expected %b/%0d",
                         i, gnt_o[0], enc_o[0], exp_g, i % 4);
            end
        end
    endtask

    task automatic test_ack_hold();
        do_reset();
        ack_v[1] = 4'b0000;
        req_v[1] = 4'b0010;
        cycle();
        n_checks++;
        if (gnt_o[1] !== 4'b0010) begin
            n_fail++;
            $display("FAIL ack_first_grant: got %b expected 0010", gnt_o[1]);
        end
        req_v[1] = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (gnt_o[1] !== 4'b0010) begin
                n_fail++;
                $display("FAIL ack_hold cycle %0d: got %b expected 0010", i, gnt_o[1]);
            end
        end
        ack_v[1] = 4'b0010;
        cycle();
        n_checks++;
        if (gnt_o[1] !== 4'b0100) begin
            n_fail++;
            $display("FAIL ack_release: got %b expected 0100", gnt_o[1]);
        end
        ack_v[1] = 4'b1000;
        cycle();
        n_checks++;
        if (gnt_o[1] !== 4'b0100) begin
            n_fail++;
            $display("FAIL ack_foreign_ignored: got %b expected 0100", gnt_o[1]);
        end
        ack_v[1] = 4'b0100;
        cycle();
        n_checks++;
        if (gnt_o[1] !== 4'b1000) begin
            n_fail++;
            $display("FAIL ack_release_next: got %b expected 1000", gnt_o[1]);
        end
        ack_v[1] = 4'b0000;
    endtask

    task automatic test_fixed_priority();
        req_v[2] = 4'b1010;
        req_v[3] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (gnt_o[2] !== 4'b0010) begin
                n_fail++;
                $display("FAIL fixed_high cycle %0d: got %b expected 0010", i, gnt_o[2]);
            end
            n_checks++;
            if (gnt_o[3] !== 4'b1000) begin
                n_fail++;
                $display("FAIL fixed_low cycle %0d: got %b expected 1000", i, gnt_o[3]);
            end
        end
    endtask

    task automatic test_skip_holes();
        do_reset();
        req_v[0] = 4'b0001;
        cycle();
        req_v[0] = 4'b1001;
        cycle();
        n_checks++;
        if (gnt_o[0] !== 4'b1000) begin
            n_fail++;
            $display("FAIL skip_holes: got %b expected 1000", gnt_o[0]);
        end
        req_v[0] = 4'b0001;
        cycle();
        n_checks++;
        if (gnt_o[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL mask_wrap: got %b expected 0001", gnt_o[0]);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        ack_v[1] = 4'b0000;
        req_v[1] = 4'b0100;
        req_v[0] = 4'b0001;
        cycle();
        cycle();
        n_checks++;
        if (gnt_o[1] !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_grant_held: got %b expected 0100", gnt_o[1]);
        end
        rst_n = 1'b0;
        req_v[0] = 4'b0011;
        cycle();
        n_checks++;
        if (gnt_o[1] !== 4'b0000 || vld_o[1] !== 1'b0 || enc_o[1] !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_grant_reset: got %b/%b/%0d expected 0000/0/0",
                     gnt_o[1], vld_o[1], enc_o[1]);
        end
        rst_n = 1'b1;
        req_v[1] = 4'b0110;
        cycle();
        n_checks++;
        if (gnt_o[1] !== 4'b0010) begin
            n_fail++;
            $display("FAIL after_reset_grant: got %b expected 0010", gnt_o[1]);
        end
        n_checks++;
        if (gnt_o[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL mask_reset: got %b expected 0001", gnt_o[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            for (int d = 0; d < NDUT; d++) begin
                req_v[d] = 4'($urandom_range(0, 15));
                ack_v[d] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            end
            cycle();
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (gnt_o[d] !== exp_gnt(d) || vld_o[d] !== m_valid[d] ||
                    enc_o[d] !== 2'(m_g[d])) begin
                    n_fail++;
                    $display("FAIL random dut%0d step %0d: got %b/%b/%0d expected %b/%b/%0d",
                             d, i, gnt_o[d], vld_o[d], enc_o[d], exp_gnt(d), m_valid[d], m_g[d]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        req_v = '0;
        ack_v = '0;
        for (int d = 0; d < NDUT; d++) begin
            m_valid[d] = 1'b0;
            m_g[d]     = 0;
            m_last[d]  = CFG_HI[d] ? 3 : 0;
        end
        test_reset();
        test_rr_rotation();
        test_ack_hold();
        test_fixed_priority();
        test_skip_holes();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
